// File: rtl/water_led_checker_if.sv
// water_led_checker_if
//   Groups the observed LED bus and the checker's status outputs.
//   master : the side driving the LEDs and reading status (chaser/bench)
//   slave  : the checker itself
//   Signals:
//     led_in   [3:0]  LED bus under observation
//     locked          high while tracking a verified rotation
//     err_seq         one-clock pulse on illegal pattern / wrong step
//     err_time        one-clock pulse on dwell outside limits
//     step_cnt [15:0] verified steps, wrapping
//     err_cnt  [7:0]  error pulses, saturating
//     cur_idx  [1:0]  index of currently lit LED
interface water_led_checker_if;
   logic [3:0]  led_in;
   logic        locked;
   logic        err_seq;
   logic        err_time;
   logic [15:0] step_cnt;
   logic [7:0]  err_cnt;
   logic [1:0]  cur_idx;

   modport master (output led_in,
                   input  locked, err_seq, err_time, step_cnt, err_cnt, cur_idx);
   modport slave  (input  led_in,
                   output locked, err_seq, err_time, step_cnt, err_cnt, cur_idx);
endinterface

// File: rtl/water_led_checker.sv
// water_led_checker
//   Receive-side monitor for a 4-bit walking-LED chaser. Locks onto the
//   one-hot rotation 0001->0010->0100->1000->0001 and checks both the step
//   order and the dwell of every pattern (CNT_MAX+1 clocks, +/- TOL).
//   Ports:
//     sys_clk  system clock, rising edge
//     sys_rst  synchronous active-high reset
//     bus      water_led_checker_if.slave (led_in in; status outputs out)
//   Build option:
//     LED_IN_SYNC_EN  when defined, led_in passes a 2-flop synchronizer
//                     ahead of the input register (latency 4 instead of 2).
module water_led_checker #(
   parameter int unsigned      CNT_W      = 25,
   parameter logic [CNT_W-1:0] CNT_MAX    = 25'd24999999,
   parameter logic [CNT_W-1:0] TOL        = '0,
   parameter bit               ACTIVE_LOW = 1'b0
)(
   input  logic               sys_clk,
   input  logic               sys_rst,
   water_led_checker_if.slave bus
);

   typedef enum logic [1:0] {SEARCH, SYNC, TRACK} state_t;

   // Dwell window, one bit wider so CNT_MAX+1+TOL cannot wrap.
   localparam logic [CNT_W:0] DW_NOM = {1'b0, CNT_MAX} + (CNT_W+1)'(1);
   localparam logic [CNT_W:0] DW_LO  = DW_NOM - {1'b0, TOL};
   localparam logic [CNT_W:0] DW_HI  = DW_NOM + {1'b0, TOL};

   logic [3:0]       led_src;
   logic [3:0]       led_q;
   logic [3:0]       led_d;
   logic [3:0]       prev;
   logic [CNT_W-1:0] dwell;
   logic [CNT_W-1:0] dwell_now;
   state_t           state;

   logic             locked_r;
   logic             err_seq_r;
   logic             err_time_r;
   logic [15:0]      step_cnt_r;
   logic [7:0]       err_cnt_r;
   logic [1:0]       cur_idx_r;

`ifdef LED_IN_SYNC_EN
   logic [3:0] sync1, sync2;
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.led_in;
         sync2 <= sync1;
      end
   end
   assign led_src = sync2;
`else
   assign led_src = bus.led_in;
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst) led_q <= '0;
      else         led_q <= ACTIVE_LOW ? ~led_src : led_src;
   end

   // dwell holds the length of the pattern seen up to the previous cycle;
   // dwell_now is the length including the current cycle.
   always_comb begin
      dwell_now = dwell;
      if (led_q != led_d)  dwell_now = CNT_W'(1);
      else if (dwell != '1) dwell_now = dwell + CNT_W'(1);
   end

   logic            valid, changed, is_next, in_win, stuck;
   logic            seq_hit, time_hit;
   logic [1:0]      idx;
   logic [CNT_W:0]  dwell_x;

   assign dwell_x = {1'b0, dwell};
   assign valid   = $onehot(led_q);
   assign idx     = {led_q[3] | led_q[2], led_q[3] | led_q[1]};
   assign changed = (led_q != prev);
   // prev is one-hot in SYNC/TRACK, so a match here implies a valid pattern
   assign is_next = (led_q == {prev[2:0], prev[3]});
   // On a change, dwell is the full length of the pattern just left.
   assign in_win  = (dwell_x >= DW_LO) && (dwell_x <= DW_HI);
   // Current cycle would be dwell CNT_MAX+2+TOL with no change.
   assign stuck   = (dwell_x == DW_HI);

   assign seq_hit  = (state == SYNC || state == TRACK) && changed && !is_next;
   assign time_hit = (state == TRACK) &&
                     ((changed && is_next && !in_win) || (!changed && stuck));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         led_d      <= '0;
         prev       <= '0;
         dwell      <= '0;
         state      <= SEARCH;
         locked_r   <= 1'b0;
         err_seq_r  <= 1'b0;
         err_time_r <= 1'b0;
         step_cnt_r <= '0;
         err_cnt_r  <= '0;
         cur_idx_r  <= '0;
      end else begin
         led_d      <= led_q;
         dwell      <= dwell_now;
         err_seq_r  <= seq_hit;
         err_time_r <= time_hit && !seq_hit;
         if ((seq_hit || time_hit) && err_cnt_r != 8'hFF)
            err_cnt_r <= err_cnt_r + 8'd1;
         if (valid)
            cur_idx_r <= idx;

         case (state)
            SEARCH: begin
               locked_r <= 1'b0;
               if (valid) begin
                  prev  <= led_q;
                  state <= SYNC;
               end
            end
            SYNC: begin
               // entry dwell is partial, so no timing check here
               if (changed) begin
                  if (is_next) begin
                     prev  <= led_q;
                     state <= TRACK;
                  end else begin
                     state <= SEARCH;
                  end
               end
            end
            TRACK: begin
               if (changed) begin
                  if (!is_next) begin
                     locked_r <= 1'b0;
                     state    <= SEARCH;
                  end else if (in_win) begin
                     prev       <= led_q;
                     step_cnt_r <= step_cnt_r + 16'd1;
                     locked_r   <= 1'b1;
                  end else begin
                     prev     <= led_q;
                     locked_r <= 1'b0;
                     state    <= SYNC;
                  end
               end else if (stuck) begin
                  locked_r <= 1'b0;
                  state    <= SEARCH;
               end
            end
            default: begin
               locked_r <= 1'b0;
               state    <= SEARCH;
            end
         endcase
      end
   end

   assign bus.locked   = locked_r;
   assign bus.err_seq  = err_seq_r;
   assign bus.err_time = err_time_r;
   assign bus.step_cnt = step_cnt_r;
   assign bus.err_cnt  = err_cnt_r;
   assign bus.cur_idx  = cur_idx_r;

endmodule

// File: tb/tb_water_led_checker.sv
// tb_water_led_checker
//   Two checkers (active-high and active-low input) watch the same LED
//   sequence; a reference model predicts outputs into a queue that a
//   monitor drains and compares every cycle.
module tb_water_led_checker;
   localparam int CM      = 24;
   localparam int TV      = 0;
   localparam int RUN_SAT = (1 << 25) - 1;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   int   cyc     = 0;
   int   total   = 0;
   int   bad     = 0;

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   water_led_checker_if bus_a();
   water_led_checker_if bus_b();

   water_led_checker #(.CNT_W(25), .CNT_MAX(25'd24), .TOL(25'd0), .ACTIVE_LOW(1'b0))
      dut_a (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus_a));
   water_led_checker #(.CNT_W(25), .CNT_MAX(25'd24), .TOL(25'd0), .ACTIVE_LOW(1'b1))
      dut_b (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus_b));

   typedef struct {
      int due;
      bit locked;
      bit es;
      bit et;
      int sc;
      int ec;
      int ci;
   } exp_t;
   exp_t sbq[$];

   // reference model: run-length of each pattern plus a mode/anchor index
   logic [3:0] m_q, m_last;
   int m_run, m_mode, m_anchor, m_steps, m_errs, m_idx;
   bit m_locked;

   task automatic cmp(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, act, req);
      end
   endtask

   task model_step(input bit rst, input logic [3:0] led);
      exp_t e;
      logic [3:0] p;
      int old_run, idx;
      bit valid, moved, nxt, es, et;
      es = 0; et = 0;
      if (rst) begin
         m_q = 0; m_last = 0; m_run = 0; m_mode = 0; m_anchor = 0;
         m_steps = 0; m_errs = 0; m_idx = 0; m_locked = 0;
      end else begin
         p = m_q;
         m_q = led;
         old_run = m_run;
         if (p != m_last) m_run = 1;
         else if (m_run < RUN_SAT) m_run++;
         m_last = p;
         valid = ($countones(p) == 1);
         idx   = valid ? $clog2(p) : 0;
         moved = (p != 4'(1 << m_anchor));
         nxt   = valid && (idx == (m_anchor + 1) % 4);
         case (m_mode)
            0: if (valid) begin m_anchor = idx; m_mode = 1; end
            1: if (moved) begin
                  if (nxt) begin m_anchor = idx; m_mode = 2; end
                  else begin es = 1; m_mode = 0; end
               end
            default:
               if (moved) begin
                  if (!nxt) begin es = 1; m_locked = 0; m_mode = 0; end
                  else if (old_run >= CM + 1 - TV && old_run <= CM + 1 + TV) begin
                     m_steps = (m_steps + 1) % 65536; m_locked = 1; m_anchor = idx;
                  end else begin
                     et = 1; m_locked = 0; m_mode = 1; m_anchor = idx;
                  end
               end else if (m_run == CM + 2 + TV) begin
                  et = 1; m_locked = 0; m_mode = 0;
               end
         endcase
         if ((es || et) && m_errs < 255) m_errs++;
         if (valid) m_idx = idx;
      end
      e.due = cyc + 1; e.locked = m_locked; e.es = es; e.et = et;
      e.sc = m_steps; e.ec = m_errs; e.ci = m_idx;
      sbq.push_back(e);
   endtask

   task drive(input bit r, input logic [3:0] led, input int n);
      repeat (n) begin
         @(negedge sys_clk);
         sys_rst      = r;
         bus_a.led_in = led;
         bus_b.led_in = ~led;
         model_step(r, led);
      end
   endtask

   // monitor: compare both DUTs against the expected entry due this cycle
   always @(negedge sys_clk) begin
      exp_t e;
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
         e = sbq.pop_front();
         total++; bad++;
         $display("FAIL sb_order: entry due %0d still queued at %0d", e.due, cyc);
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         e = sbq.pop_front();
         cmp("a_locked",   int'(bus_a.locked),   int'(e.locked));
         cmp("a_err_seq",  int'(bus_a.err_seq),  int'(e.es));
         cmp("a_err_time", int'(bus_a.err_time), int'(e.et));
         cmp("a_step_cnt", int'(bus_a.step_cnt), e.sc);
         cmp("a_err_cnt",  int'(bus_a.err_cnt),  e.ec);
         cmp("a_cur_idx",  int'(bus_a.cur_idx),  e.ci);
         cmp("b_locked",   int'(bus_b.locked),   int'(e.locked));
         cmp("b_err_seq",  int'(bus_b.err_seq),  int'(e.es));
         cmp("b_err_time", int'(bus_b.err_time), int'(e.et));
         cmp("b_step_cnt", int'(bus_b.step_cnt), e.sc);
         cmp("b_err_cnt",  int'(bus_b.err_cnt),  e.ec);
         cmp("b_cur_idx",  int'(bus_b.cur_idx),  e.ci);
      end
   end

   task check_a(input string nm, input int lk, input int sc, input int ec);
      cmp({nm, "_locked"},   int'(bus_a.locked),   lk);
      cmp({nm, "_step_cnt"}, int'(bus_a.step_cnt), sc);
      cmp({nm, "_err_cnt"},  int'(bus_a.err_cnt),  ec);
   endtask

   initial begin
      int pos, r, len;
      logic [3:0] pat;
      bus_a.led_in = 4'h0;
      bus_b.led_in = 4'hF;

      // reset and first lock
      drive(1, 4'b0000, 2);
      drive(0, 4'b0000, 1);
      check_a("reset", 0, 0, 0);
      cmp("reset_cur_idx", int'(bus_a.cur_idx), 0);
      drive(0, 4'b0001, 25);
      drive(0, 4'b0010, 25);
      drive(0, 4'b0100, 2);
      cmp("lock_edge_before", int'(bus_a.locked), 0);
      drive(0, 4'b0100, 1);
      cmp("lock_edge_at", int'(bus_a.locked), 1);
      drive(0, 4'b0100, 22);
      drive(0, 4'b1000, 25);
      drive(0, 4'b0001, 25);
      check_a("run1", 1, 3, 0);

      // wrong step 0010 -> 1000
      drive(0, 4'b0010, 25);
      drive(0, 4'b1000, 25);
      check_a("jump", 0, 4, 1);
      drive(0, 4'b0001, 25);
      drive(0, 4'b0010, 25);
      check_a("relock1", 1, 5, 1);

      // short dwell
      drive(0, 4'b0100, 20);
      drive(0, 4'b1000, 25);
      check_a("short", 0, 6, 2);
      drive(0, 4'b0001, 25);
      check_a("short_sync", 0, 6, 2);
      drive(0, 4'b0010, 25);
      check_a("short_relock", 1, 7, 2);

      // stuck pattern
      drive(0, 4'b0100, 40);
      check_a("stuck", 0, 8, 3);
      drive(0, 4'b1000, 25);
      drive(0, 4'b0001, 25);
      check_a("relock2", 1, 9, 3);

      // reset mid-track
      drive(0, 4'b0010, 10);
      drive(1, 4'b0010, 1);
      drive(0, 4'b0010, 1);
      check_a("midrst", 0, 0, 0);
      cmp("midrst_err_seq", int'(bus_a.err_seq), 0);
      cmp("midrst_cur_idx", int'(bus_a.cur_idx), 0);
      drive(0, 4'b0010, 24);
      drive(0, 4'b0100, 25);
      drive(0, 4'b1000, 25);
      drive(0, 4'b0001, 25);
      check_a("relock3", 1, 2, 0);

      // illegal pattern: cur_idx holds
      drive(0, 4'b0011, 5);
      check_a("illegal", 0, 2, 1);
      cmp("illegal_cur_idx", int'(bus_a.cur_idx), 0);

      // randomized rotation with timing jitter, bad patterns and resets
      pos = 0;
      for (int i = 0; i < 50; i++) begin
         r = $urandom_range(0, 99);
         if (r < 6) begin
            pat = 4'($urandom_range(0, 15));
         end else if (r < 8) begin
            drive(1, 4'($urandom_range(0, 15)), 1);
            pos = (pos + 1) % 4;
            pat = 4'(1 << pos);
         end else begin
            pos = (pos + 1) % 4;
            pat = 4'(1 << pos);
         end
         len = (r % 5 == 0) ? $urandom_range(20, 30) : $urandom_range(24, 26);
         drive(0, pat, len);
      end

      // drain the scoreboard, bounded
      for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge sys_clk);
      if (sbq.size() > 0) begin
         total++; bad++;
         $display("FAIL sb_drain: %0d entries left, want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
